// File: rtl/timer_cmp_ctrl_if.sv
// Word-register bus between the peripheral decoder and timer_cmp_ctrl.
// The master drives addr/WD/WE; the slave returns combinational RD.
interface timer_cmp_ctrl_if;
  logic [4:0]  addr;
  logic [31:0] WD;
  logic        WE;
  logic [31:0] RD;

  modport master (output addr, output WD, output WE, input RD);
  modport slave  (input addr, input WD, input WE, output RD);
endinterface

// File: rtl/timer_cmp_ctrl.sv
// N_CH compare channels against the shared timer count, sticky PENDING, single level irq.
// Optional macro TIMER_CMP_OVF_EN adds the timer wrap flag as PENDING[4]/IRQ_MASK[4].
module timer_cmp_ctrl #(
  parameter int N_CH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       timer_value,
  timer_cmp_ctrl_if.slave   bus,
  output logic              irq
);

`ifdef TIMER_CMP_OVF_EN
  localparam int PW       = 5;
  localparam int OVF_MASK = 32'h10;
`else
  localparam int PW       = N_CH;
  localparam int OVF_MASK = 0;
`endif
  localparam logic [PW-1:0] VALID = PW'(((1 << N_CH) - 1) | OVF_MASK);

  typedef enum logic {IDLE, ARMED} ch_state_t;

  logic [N_CH-1:0] fire;
  logic [31:0]     cmp_rd  [N_CH];
  logic [31:0]     per_rd  [N_CH];
  logic [31:0]     ctrl_rd [N_CH];
  logic [PW-1:0]   pending_reg;
  logic [PW-1:0]   mask_reg;
  logic [PW-1:0]   set_vec;
  logic [PW-1:0]   w1c;
  logic            irq_reg;
  logic [31:0]     rd_data;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      ch_state_t   state_reg;
      logic [31:0] cmp_reg;
      logic [31:0] period_reg;
      logic        periodic_reg;
      logic        sel;
      logic        cmp_we;
      logic        per_we;
      logic        ctrl_we;
      logic        reload;

      assign sel     = bus.WE && (bus.addr[4:2] == 3'(gi + 1));
      assign cmp_we  = sel && (bus.addr[1:0] == 2'd0);
      assign per_we  = sel && (bus.addr[1:0] == 2'd1);
      assign ctrl_we = sel && (bus.addr[1:0] == 2'd2);
      assign reload  = periodic_reg && (period_reg != 32'd0);

      // A disabling CTRL write in the match cycle suppresses the fire.
      assign fire[gi] = (state_reg == ARMED) && (timer_value == cmp_reg)
                        && !(ctrl_we && !bus.WD[0]);

      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg    <= IDLE;
          cmp_reg      <= '0;
          period_reg   <= '0;
          periodic_reg <= 1'b0;
        end else begin
          if (per_we) period_reg <= bus.WD;
          // A bus write to CMP replaces any auto-reload in the same cycle.
          if (cmp_we)
            cmp_reg <= bus.WD;
          else if (fire[gi] && reload)
            cmp_reg <= cmp_reg + period_reg;
          if (ctrl_we) begin
            periodic_reg <= bus.WD[1];
            state_reg    <= bus.WD[0] ? ARMED : IDLE;
          end else if (fire[gi] && !reload) begin
            state_reg <= IDLE;
          end
        end
      end

      assign cmp_rd[gi]  = cmp_reg;
      assign per_rd[gi]  = period_reg;
      assign ctrl_rd[gi] = {30'd0, periodic_reg, state_reg == ARMED};
    end
  endgenerate

`ifdef TIMER_CMP_OVF_EN
  logic [31:0] prev_timer_reg;
  logic        ovf;

  always_ff @(posedge clk) begin
    if (rst) prev_timer_reg <= '0;
    else     prev_timer_reg <= timer_value;
  end

  // Only a genuine all-ones to zero step counts, not a write that lands on 0.
  assign ovf = (prev_timer_reg == 32'hFFFF_FFFF) && (timer_value == 32'd0);
`endif

  always_comb begin
    set_vec = '0;
    set_vec[N_CH-1:0] = fire;
`ifdef TIMER_CMP_OVF_EN
    set_vec[4] = ovf;
`endif
  end

  assign w1c = (bus.WE && (bus.addr == 5'd0)) ? bus.WD[PW-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= '0;
      mask_reg    <= '0;
      irq_reg     <= 1'b0;
    end else begin
      // Set beats clear when a match and W1C hit the same bit.
      pending_reg <= (pending_reg & ~w1c) | set_vec;
      if (bus.WE && (bus.addr == 5'd1))
        mask_reg <= bus.WD[PW-1:0] & VALID;
      irq_reg <= |(pending_reg & mask_reg);
    end
  end

  assign irq = irq_reg;

  always_comb begin
    rd_data = '0;
    if (bus.addr == 5'd0)
      rd_data = 32'(pending_reg);
    else if (bus.addr == 5'd1)
      rd_data = 32'(mask_reg);
    for (int c = 0; c < N_CH; c++) begin
      if (bus.addr[4:2] == 3'(c + 1)) begin
        case (bus.addr[1:0])
          2'd0:    rd_data = cmp_rd[c];
          2'd1:    rd_data = per_rd[c];
          2'd2:    rd_data = ctrl_rd[c];
          default: rd_data = '0;
        endcase
      end
    end
  end

  assign bus.RD = rd_data;

endmodule
